panel_switch_conditioner: RTL
=============================

Name: panel_switch_conditioner

Overview:
- Front-panel input stage between the board's raw active-low push-buttons (nBUT1, nBUT2) and the CPU's sw_RUN / sw_HALT / sw_RESET / sw_CLEAR inputs.
- Per button: synchronises to SYSCLK, then debounces.
- Button 1: a short press becomes a one-cycle RUN pulse; a long press becomes a one-cycle HALT pulse.
- Button 2: a press becomes a stretched RESET/CLEAR pulse.
- Also generates a power-on RESET/CLEAR stretch after the block's own reset releases.

Parameters:
- DB_CYCLES, 125000, consecutive stable synchronised samples needed to accept a button change (10 ms at 12.5 MHz); minimum 2.
- LONG_CYCLES, 12500000, debounced hold time on button 1 that makes a press a HALT instead of a RUN (1 s); must exceed 1.
- RST_CYCLES, 16, length in cycles of every RESET/CLEAR pulse; minimum 1.

Ports:
- SYSCLK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- nBUT1  input  1  raw button 1, active-low, asynchronous to SYSCLK.
- nBUT2  input  1  raw button 2, active-low, asynchronous to SYSCLK.
- sw_RUN  output  1  one-cycle pulse: short press of button 1.
- sw_HALT  output  1  one-cycle pulse: long press of button 1.
- sw_RESET  output  1  high for RST_CYCLES after a button 2 press or after power-on.
- sw_CLEAR  output  1  identical to sw_RESET, driven from its own register.
- but1_db  output  1  debounced button 1 level, 1 = pressed.
- but2_db  output  1  debounced button 2 level, 1 = pressed.

Behaviour:
- All outputs are registered.
- Reset values:
  - sw_RUN = 0, sw_HALT = 0, but1_db = 0, but2_db = 0.
  - sw_RESET = 1, sw_CLEAR = 1.
  - Synchroniser flops = 1 (released).
  - Stretch counter = RST_CYCLES.
  - Button 1 FSM = IDLE.
- Synchroniser:
  - Two flops per button.
  - The internal active-high pressed signal is the inverted second-stage output.
- Debouncer, one per button:
  - Counter width is $clog2(DB_CYCLES).
  - When the synchronised level equals the debounced level, the counter clears.
  - When they differ, the counter increments.
  - On the cycle the counter is DB_CYCLES-1 and the levels still differ, the debounced level toggles and the counter clears.
  - Any glitch shorter than DB_CYCLES cycles produces no change.
  - Pin-to-but*_db latency is 2 + DB_CYCLES cycles.
- Stretch counter:
  - Each cycle it decrements if nonzero.
  - It reloads to RST_CYCLES on a rising edge of but2_db; a reload while already nonzero restarts the full length.
  - sw_RESET and sw_CLEAR are high exactly while the counter is nonzero.
  - After RESET deasserts they stay high for RST_CYCLES more cycles, then fall.
- Button 1 FSM, states IDLE / PRESSED / LONG:
  - IDLE: on a but1_db rising edge go to PRESSED and clear the hold counter (width $clog2(LONG_CYCLES)).
  - PRESSED, but1_db falls: pulse sw_RUN high for exactly one cycle, then go to IDLE.
  - PRESSED, hold counter reaches LONG_CYCLES-1 while still pressed: pulse sw_HALT high for one cycle, then go to LONG.
  - PRESSED, if release and counter terminal count coincide in the same cycle, release wins: RUN only.
  - LONG: wait for but1_db to fall, then go to IDLE with no RUN pulse.
  - sw_RUN therefore fires on release, one cycle after but1_db falls.
- Suppression while sw_RESET is high:
  - The FSM is forced to IDLE.
  - sw_RUN and sw_HALT are held at 0.
  - A button 1 press already in progress when the stretch ends is ignored until it is released and pressed again. IDLE only accepts a rising edge.
- sw_RUN and sw_HALT are never high in the same cycle.
- Both buttons pressed together: button 2 takes priority through suppression; no RUN or HALT is produced.
- RESET asserted mid-operation: all state returns immediately, asynchronously, to the reset values.

Test Plan (DB_CYCLES=4, LONG_CYCLES=20, RST_CYCLES=3):
- Power-on:
  - Stimulus: hold RESET 5 cycles, then release; buttons idle (1).
  - Required: sw_RESET = sw_CLEAR = 1 during reset and for 3 cycles after, then 0; sw_RUN = sw_HALT = 0 throughout.
- Glitch rejection:
  - Stimulus: nBUT1 low for 3 cycles, then high.
  - Required: but1_db stays 0; no sw_RUN pulse.
- Short press:
  - Stimulus: nBUT1 low for 10 cycles, then high.
  - Required: but1_db rises 6 cycles after the pin falls; exactly one sw_RUN pulse, one cycle after but1_db falls; sw_HALT stays 0.
- Long press:
  - Stimulus: nBUT1 low for 40 cycles.
  - Required: one sw_HALT pulse 20 cycles after but1_db rises; no sw_RUN pulse on release.
- Reset button with retrigger:
  - Stimulus: press nBUT2; press it again (after a clean debounced release) while sw_RESET is still high.
  - Required: sw_RESET / sw_CLEAR high 3 cycles from the first but2_db rise; the second rise reloads, giving 3 more cycles from that rise.
- Suppression:
  - Stimulus: press nBUT1 during an active stretch; hold it past the stretch end; release.
  - Required: no sw_RUN and no sw_HALT pulse.

Source files
------------

// File: rtl/panel_switch_conditioner.sv
// Front-panel button conditioner: two-flop sync and debounce per button, RUN/HALT on button 1,
// stretched RESET/CLEAR on button 2 or after power-on.
module panel_switch_conditioner #(
    parameter int unsigned DB_CYCLES   = 125000,
    parameter int unsigned LONG_CYCLES = 12500000,
    parameter int unsigned RST_CYCLES  = 16
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic nBUT1,
    input  logic nBUT2,
    output logic sw_RUN,
    output logic sw_HALT,
    output logic sw_RESET,
    output logic sw_CLEAR,
    output logic but1_db,
    output logic but2_db
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
    localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LOAD = RST_W'(RST_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        pressed;
    logic [1:0]        db;
    logic [DB_W-1:0]   db_cnt [2];
    logic [1:0]        flip;
    logic [1:0]        rise;
    logic [RST_W-1:0]  stretch;
    logic [RST_W-1:0]  stretch_next;
    logic              suppress;
    logic [LONG_W-1:0] hold;
    state_t            state;

    assign pressed = ~sync2;
    assign but1_db = db[0];
    assign but2_db = db[1];

    // Rising edges are taken from the debouncer's toggle event so the FSM and
    // stretch counter react on the same edge the debounced level rises.
    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            flip[i] = (pressed[i] != db[i]) && (db_cnt[i] == DB_MAX);
        end
        rise = flip & ~db;
    end

    always_comb begin
        stretch_next = stretch;
        if (rise[1]) begin
            stretch_next = RST_LOAD;
        end else if (stretch != '0) begin
            stretch_next = stretch - RST_W'(1);
        end
        suppress = (stretch_next != '0);
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {nBUT2, nBUT1};
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (pressed[i] == db[i] || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
                if (flip[i]) begin
                    db[i] <= ~db[i];
                end
            end
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            stretch  <= RST_LOAD;
            sw_RESET <= 1'b1;
            sw_CLEAR <= 1'b1;
        end else begin
            stretch  <= stretch_next;
            sw_RESET <= suppress;
            sw_CLEAR <= suppress;
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            hold    <= '0;
            sw_RUN  <= 1'b0;
            sw_HALT <= 1'b0;
        end else begin
            sw_RUN  <= 1'b0;
            sw_HALT <= 1'b0;
            if (suppress) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise[0]) begin
                            state <= PRESSED;
                            hold  <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!db[0]) begin
                            sw_RUN <= 1'b1;
                            state  <= IDLE;
                        end else if (hold == LONG_MAX) begin
                            sw_HALT <= 1'b1;
                            state   <= LONG;
                        end else begin
                            hold <= hold + LONG_W'(1);
                        end
                    end
                    LONG: begin
                        if (!db[0]) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
